// File: rtl/bank_sc_arbiter_if.sv
// Request-side and SC-side signal bundle for the bank SC arbiter.
// The slave modport is the arbiter's view of the bundle. The master modport is the view
// of the requesters and the SC together.
interface bank_sc_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid_i;
  logic [N_REQ-1:0]   req_ready_o;
  logic [N_REQ*3-1:0] req_opcode_i;
  logic [N_REQ*7-1:0] req_set_way_offset_i;
  logic [N_REQ*8-1:0] req_wbuffer_id_i;
  logic [N_REQ*3-1:0] req_rob_num_i;
  logic [N_REQ*2-1:0] req_dirty_offset0_i;
  logic [N_REQ*2-1:0] req_dirty_offset1_i;

  logic               isu_sc_valid_o;
  logic               isu_sc_ready_i;
  logic [1:0]         isu_sc_channel_id_o;
  logic [2:0]         isu_sc_opcode_o;
  logic [6:0]         isu_sc_set_way_offset_o;
  logic [7:0]         isu_sc_wbuffer_id_o;
  logic [2:0]         isu_sc_xbar_rob_num_o;
  logic [1:0]         isu_sc_cacheline_dirty_offset0_o;
  logic [1:0]         isu_sc_cacheline_dirty_offset1_o;

  logic               done_valid_o;
  logic [1:0]         done_channel_id_o;
  logic               busy_o;
  logic               error_o;

  modport slave (
    input  req_valid_i, req_opcode_i, req_set_way_offset_i, req_wbuffer_id_i,
           req_rob_num_i, req_dirty_offset0_i, req_dirty_offset1_i, isu_sc_ready_i,
    output req_ready_o, isu_sc_valid_o, isu_sc_channel_id_o, isu_sc_opcode_o,
           isu_sc_set_way_offset_o, isu_sc_wbuffer_id_o, isu_sc_xbar_rob_num_o,
           isu_sc_cacheline_dirty_offset0_o, isu_sc_cacheline_dirty_offset1_o,
           done_valid_o, done_channel_id_o, busy_o, error_o
  );

  modport master (
    output req_valid_i, req_opcode_i, req_set_way_offset_i, req_wbuffer_id_i,
           req_rob_num_i, req_dirty_offset0_i, req_dirty_offset1_i, isu_sc_ready_i,
    input  req_ready_o, isu_sc_valid_o, isu_sc_channel_id_o, isu_sc_opcode_o,
           isu_sc_set_way_offset_o, isu_sc_wbuffer_id_o, isu_sc_xbar_rob_num_o,
           isu_sc_cacheline_dirty_offset0_o, isu_sc_cacheline_dirty_offset1_o,
           done_valid_o, done_channel_id_o, busy_o, error_o
  );
endinterface

// File: rtl/bank_sc_arbiter.sv
// Four-channel round-robin arbiter that feeds the bank SRAM controller request port.
// It latches the command of the winning channel and holds it until the SC signals done.
// When a new request is waiting at completion, it is granted in the same cycle with no bubble.
// It also provides a completion pulse and a sticky hang-detect error flag.
module bank_sc_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit WB_PRIO        = 1'b1
) (
  input logic              clk_i,
  input logic              rst_i,
  bank_sc_arbiter_if.slave bus
);
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
  localparam logic [2:0] OP_WB  = 3'd3;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       last_grant;
  logic [7:0]       tmo_cnt;
  logic             err_flag;

  logic [1:0]       chan_p1;
  logic [2:0]       opcode_p1;
  logic [6:0]       swo_p1;
  logic [7:0]       wbid_p1;
  logic [2:0]       rob_p1;
  logic [1:0]       dirty0_p1;
  logic [1:0]       dirty1_p1;
  logic             vld_p1;

  logic [N_REQ-1:0] wb_req;
  logic [N_REQ-1:0] cand;
  logic [2:0]       pick;
  logic             grant_found;
  logic [1:0]       grant_idx;
  logic             grant_fire;
  logic             done_fire;

  // Search starts at the channel after 'last' and returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] mask, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = 3'b000;
    // Walk from the farthest to the nearest channel so that the nearest valid one wins.
    for (int i = N_REQ; i >= 1; i--) begin
      idx = last + 2'(i);
      if (mask[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  // Stall counter saturates instead of wrapping so a long hang keeps reading as a hang.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Candidate selection: write-backs preempt round-robin order when any is pending.
  always_comb begin
    wb_req = '0;
    for (int k = 0; k < N_REQ; k++)
      wb_req[k] = bus.req_valid_i[k] && (bus.req_opcode_i[k*3 +: 3] == OP_WB);
    cand        = (WB_PRIO && (wb_req != '0)) ? wb_req : bus.req_valid_i;
    pick        = rr_pick(cand, last_grant);
    grant_found = pick[2];
    grant_idx   = pick[1:0];
  end

  // FSM next state plus grant/done decisions; reset suppresses both pulses.
  always_comb begin
    state_d    = state_q;
    grant_fire = 1'b0;
    done_fire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          grant_fire = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (bus.isu_sc_ready_i) begin
          done_fire = 1'b1;
          if (grant_found) grant_fire = 1'b1;
          else             state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      grant_fire = 1'b0;
      done_fire  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // p0 -> p1: latch the winner's command, track last grant, stall count and error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= 2'd3;
      tmo_cnt    <= 8'd0;
      err_flag   <= 1'b0;
      chan_p1    <= 2'd0;
      opcode_p1  <= 3'd0;
      swo_p1     <= 7'd0;
      wbid_p1    <= 8'd0;
      rob_p1     <= 3'd0;
      dirty0_p1  <= 2'd0;
      dirty1_p1  <= 2'd0;
    end else begin
      if (grant_fire) begin
        last_grant <= grant_idx;
        tmo_cnt    <= 8'd0;
        chan_p1    <= grant_idx;
        opcode_p1  <= bus.req_opcode_i[int'(grant_idx)*3 +: 3];
        swo_p1     <= bus.req_set_way_offset_i[int'(grant_idx)*7 +: 7];
        wbid_p1    <= bus.req_wbuffer_id_i[int'(grant_idx)*8 +: 8];
        rob_p1     <= bus.req_rob_num_i[int'(grant_idx)*3 +: 3];
        dirty0_p1  <= bus.req_dirty_offset0_i[int'(grant_idx)*2 +: 2];
        dirty1_p1  <= bus.req_dirty_offset1_i[int'(grant_idx)*2 +: 2];
      end else if ((state_q == BUSY) && !bus.isu_sc_ready_i) begin
        tmo_cnt <= sat_inc8(tmo_cnt);
        if (sat_inc8(tmo_cnt) == TO_LIM) err_flag <= 1'b1;
      end
    end
  end

  assign vld_p1 = (state_q == BUSY);

  assign bus.req_ready_o                      = grant_fire ? (N_REQ'(1) << grant_idx) : '0;
  assign bus.isu_sc_valid_o                   = vld_p1;
  assign bus.busy_o                           = vld_p1;
  assign bus.isu_sc_channel_id_o              = chan_p1;
  assign bus.isu_sc_opcode_o                  = opcode_p1;
  assign bus.isu_sc_set_way_offset_o          = swo_p1;
  assign bus.isu_sc_wbuffer_id_o              = wbid_p1;
  assign bus.isu_sc_xbar_rob_num_o            = rob_p1;
  assign bus.isu_sc_cacheline_dirty_offset0_o = dirty0_p1;
  assign bus.isu_sc_cacheline_dirty_offset1_o = dirty1_p1;
  assign bus.done_valid_o                     = done_fire;
  assign bus.done_channel_id_o                = done_fire ? chan_p1 : 2'd0;
  assign bus.error_o                          = err_flag;
endmodule

// File: tb/tb_bank_sc_arbiter.sv
// Testbench for bank_sc_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level reference model.
module tb_bank_sc_arbiter;
  localparam int TIMEOUT = 255;
  localparam bit WBP     = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bank_sc_arbiter_if #(.N_REQ(4)) ifc ();

  bank_sc_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(TIMEOUT), .WB_PRIO(WBP)) dut (
    .clk_i(clk), .rst_i(rst), .bus(ifc)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit         m_busy, m_err;
  int         m_chan, m_last, m_cnt;
  logic [2:0] m_op;
  logic [6:0] m_swo;
  logic [7:0] m_wbid;
  logic [2:0] m_rob;
  logic [1:0] m_d0, m_d1;
  // Expected combinational outputs for the current cycle
  int         e_grant;
  logic [3:0] e_ready;
  logic       e_done;
  logic [1:0] e_done_ch;

  function automatic logic [2:0] op_of(int c);
    return ifc.req_opcode_i[c*3 +: 3];
  endfunction

  task automatic clear_inputs();
    ifc.req_valid_i = '0; ifc.req_opcode_i = '0; ifc.req_set_way_offset_i = '0;
    ifc.req_wbuffer_id_i = '0; ifc.req_rob_num_i = '0; ifc.req_dirty_offset0_i = '0;
    ifc.req_dirty_offset1_i = '0; ifc.isu_sc_ready_i = 1'b0;
  endtask

  task automatic rand_payload();
    ifc.req_set_way_offset_i = 28'($urandom); ifc.req_wbuffer_id_i = $urandom;
    ifc.req_rob_num_i = 12'($urandom); ifc.req_dirty_offset0_i = 8'($urandom);
    ifc.req_dirty_offset1_i = 8'($urandom);
  endtask

  task automatic model_eval();
    bit any_wb, slot;
    int c;
    e_grant = -1; e_ready = '0; e_done = 1'b0; e_done_ch = 2'd0;
    if (rst) return;
    any_wb = 1'b0;
    for (int k = 0; k < 4; k++) if (ifc.req_valid_i[k] && op_of(k) == 3'd3) any_wb = 1'b1;
    slot = !m_busy || ifc.isu_sc_ready_i;
    if (slot) begin
      for (int s = 1; s <= 4; s++) begin
        c = (m_last + s) % 4;
        if (e_grant < 0 && ifc.req_valid_i[c] && (!(WBP && any_wb) || op_of(c) == 3'd3)) e_grant = c;
      end
    end
    if (e_grant >= 0) e_ready = 4'(1 << e_grant);
    if (m_busy && ifc.isu_sc_ready_i) begin e_done = 1'b1; e_done_ch = 2'(m_chan); end
  endtask

  // Advance the model by one clock using the inputs present before the edge, then clock.
  task automatic tick();
    model_eval();
    if (rst) begin
      m_busy = 0; m_err = 0; m_chan = 0; m_last = 3; m_cnt = 0;
      m_op = 0; m_swo = 0; m_wbid = 0; m_rob = 0; m_d0 = 0; m_d1 = 0;
    end else begin
      if (m_busy && !ifc.isu_sc_ready_i) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt == TIMEOUT) m_err = 1;
      end
      if (e_done && e_grant < 0) m_busy = 0;
      if (e_grant >= 0) begin
        m_op   = op_of(e_grant);
        m_swo  = ifc.req_set_way_offset_i[e_grant*7 +: 7];
        m_wbid = ifc.req_wbuffer_id_i[e_grant*8 +: 8];
        m_rob  = ifc.req_rob_num_i[e_grant*3 +: 3];
        m_d0   = ifc.req_dirty_offset0_i[e_grant*2 +: 2];
        m_d1   = ifc.req_dirty_offset1_i[e_grant*2 +: 2];
        m_chan = e_grant; m_last = e_grant; m_busy = 1; m_cnt = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_inputs();
    tick(); tick();
    ifc.req_valid_i = 4'b1111; #2;
    n_vec++; if (ifc.isu_sc_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ifc.isu_sc_valid_o); end
    n_vec++; if (ifc.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", ifc.busy_o); end
    n_vec++; if (ifc.error_o !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b want 0", ifc.error_o); end
    n_vec++; if (ifc.req_ready_o !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", ifc.req_ready_o); end
    n_vec++; if (ifc.isu_sc_opcode_o !== 3'd0 || ifc.isu_sc_channel_id_o !== 2'd0) begin n_err++; $display("FAIL reset_fields: op %0d ch %0d want 0 0", ifc.isu_sc_opcode_o, ifc.isu_sc_channel_id_o); end
    tick();
    rst = 1'b0; clear_inputs();
  endtask

  task automatic test_single();
    clear_inputs(); rand_payload();
    ifc.req_valid_i = 4'b0001; ifc.req_opcode_i = 12'h001;
    ifc.req_set_way_offset_i[6:0] = 7'h15; #2;
    n_vec++; if (ifc.req_ready_o !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", ifc.req_ready_o); end
    tick();
    ifc.req_valid_i = '0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      #2;
      n_vec++; if (ifc.isu_sc_valid_o !== 1'b1 || ifc.isu_sc_opcode_o !== 3'd1 || ifc.isu_sc_set_way_offset_o !== 7'h15)
        begin n_err++; $display("FAIL single_hold c%0d: vld %b op %0d swo %h want 1 1 15", cyc, ifc.isu_sc_valid_o, ifc.isu_sc_opcode_o, ifc.isu_sc_set_way_offset_o); end
      n_vec++; if (ifc.done_valid_o !== 1'b0) begin n_err++; $display("FAIL single_nodone c%0d: got %b want 0", cyc, ifc.done_valid_o); end
      tick();
    end
    ifc.isu_sc_ready_i = 1'b1; #2;
    n_vec++; if (ifc.done_valid_o !== 1'b1 || ifc.done_channel_id_o !== 2'd0) begin n_err++; $display("FAIL single_done: vld %b ch %0d want 1 0", ifc.done_valid_o, ifc.done_channel_id_o); end
    tick();
    ifc.isu_sc_ready_i = 1'b0; #2;
    n_vec++; if (ifc.isu_sc_valid_o !== 1'b0 || ifc.busy_o !== 1'b0) begin n_err++; $display("FAIL single_idle: vld %b busy %b want 0 0", ifc.isu_sc_valid_o, ifc.busy_o); end
  endtask

  task automatic test_fairness();
    int order[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; clear_inputs(); tick(); rst = 1'b0;
    for (int c = 0; c < 4; c++) ifc.req_opcode_i[c*3 +: 3] = 3'($urandom_range(0, 2));
    rand_payload(); ifc.req_valid_i = 4'b1111; #2;
    n_vec++; if (ifc.req_ready_o !== 4'b0001) begin n_err++; $display("FAIL fair_first: got %b want 0001", ifc.req_ready_o); end
    tick();
    for (int g = 1; g <= 5; g++) begin
      if (g == 5) ifc.req_valid_i = '0;
      for (int b = 1; b <= 2; b++) begin
        #2;
        n_vec++; if (ifc.busy_o !== 1'b1 || ifc.isu_sc_channel_id_o !== 2'(order[g-1]))
          begin n_err++; $display("FAIL fair_busy g%0d b%0d: busy %b ch %0d want 1 %0d", g, b, ifc.busy_o, ifc.isu_sc_channel_id_o, order[g-1]); end
        tick();
      end
      ifc.isu_sc_ready_i = 1'b1; #2;
      n_vec++; if (ifc.done_valid_o !== 1'b1 || ifc.done_channel_id_o !== 2'(order[g-1]))
        begin n_err++; $display("FAIL fair_done g%0d: vld %b ch %0d want 1 %0d", g, ifc.done_valid_o, ifc.done_channel_id_o, order[g-1]); end
      n_vec++; if (ifc.req_ready_o !== ((g < 5) ? 4'(1 << order[g]) : 4'b0000))
        begin n_err++; $display("FAIL fair_grant g%0d: got %b", g, ifc.req_ready_o); end
      tick();
      ifc.isu_sc_ready_i = 1'b0;
    end
    #2;
    n_vec++; if (ifc.busy_o !== 1'b0) begin n_err++; $display("FAIL fair_end: busy %b want 0", ifc.busy_o); end
  endtask

  task automatic test_wb_prio();
    rst = 1'b1; clear_inputs(); tick(); rst = 1'b0;
    rand_payload();
    ifc.req_valid_i = 4'b0110; ifc.req_opcode_i[3 +: 3] = 3'd0; ifc.req_opcode_i[6 +: 3] = 3'd3; #2;
    n_vec++; if (ifc.req_ready_o !== 4'b0100) begin n_err++; $display("FAIL wb_first: got %b want 0100", ifc.req_ready_o); end
    tick();
    ifc.req_valid_i = 4'b0010; #2;
    n_vec++; if (ifc.isu_sc_channel_id_o !== 2'd2 || ifc.isu_sc_opcode_o !== 3'd3) begin n_err++; $display("FAIL wb_cmd: ch %0d op %0d want 2 3", ifc.isu_sc_channel_id_o, ifc.isu_sc_opcode_o); end
    tick();
    ifc.isu_sc_ready_i = 1'b1; #2;
    n_vec++; if (ifc.done_channel_id_o !== 2'd2 || ifc.req_ready_o !== 4'b0010) begin n_err++; $display("FAIL wb_second: done ch %0d ready %b want 2 0010", ifc.done_channel_id_o, ifc.req_ready_o); end
    tick();
    ifc.isu_sc_ready_i = 1'b0; ifc.req_valid_i = '0; #2;
    n_vec++; if (ifc.isu_sc_channel_id_o !== 2'd1 || ifc.isu_sc_opcode_o !== 3'd0 || ifc.busy_o !== 1'b1) begin n_err++; $display("FAIL wb_cmd2: ch %0d op %0d busy %b want 1 0 1", ifc.isu_sc_channel_id_o, ifc.isu_sc_opcode_o, ifc.busy_o); end
    tick();
    ifc.isu_sc_ready_i = 1'b1; tick(); ifc.isu_sc_ready_i = 1'b0;
  endtask

  task automatic test_timeout();
    clear_inputs(); rand_payload();
    ifc.req_valid_i = 4'b1000; ifc.req_opcode_i[9 +: 3] = 3'd2; #2;
    n_vec++; if (ifc.req_ready_o !== 4'b1000) begin n_err++; $display("FAIL tmo_grant: got %b want 1000", ifc.req_ready_o); end
    tick();
    ifc.req_valid_i = '0;
    for (int k = 1; k <= 256; k++) begin
      if (k == 256) ifc.isu_sc_ready_i = 1'b1;
      #2;
      if (k == 255) begin
        n_vec++; if (ifc.error_o !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %b want 0", ifc.error_o); end
      end
      if (k == 256) begin
        n_vec++; if (ifc.error_o !== 1'b1) begin n_err++; $display("FAIL tmo_set: got %b want 1", ifc.error_o); end
        n_vec++; if (ifc.done_valid_o !== 1'b1 || ifc.done_channel_id_o !== 2'd3) begin n_err++; $display("FAIL tmo_done: vld %b ch %0d want 1 3", ifc.done_valid_o, ifc.done_channel_id_o); end
      end
      tick();
    end
    ifc.isu_sc_ready_i = 1'b0; ifc.req_valid_i = 4'b0001; ifc.req_opcode_i = '0; #2;
    n_vec++; if (ifc.error_o !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %b want 1", ifc.error_o); end
    n_vec++; if (ifc.req_ready_o !== 4'b0001) begin n_err++; $display("FAIL tmo_regrant: got %b want 0001", ifc.req_ready_o); end
    tick();
    ifc.req_valid_i = '0; #2;
    n_vec++; if (ifc.busy_o !== 1'b1 || ifc.isu_sc_channel_id_o !== 2'd0) begin n_err++; $display("FAIL tmo_busy2: busy %b ch %0d want 1 0", ifc.busy_o, ifc.isu_sc_channel_id_o); end
  endtask

  task automatic test_reset_busy();
    rst = 1'b1; #2;
    n_vec++; if (ifc.done_valid_o !== 1'b0 || ifc.req_ready_o !== 4'b0000) begin n_err++; $display("FAIL rstb_quiet: done %b ready %b want 0 0000", ifc.done_valid_o, ifc.req_ready_o); end
    tick();
    rst = 1'b0; #2;
    n_vec++; if (ifc.isu_sc_valid_o !== 1'b0 || ifc.busy_o !== 1'b0 || ifc.error_o !== 1'b0)
      begin n_err++; $display("FAIL rstb_state: vld %b busy %b err %b want 0 0 0", ifc.isu_sc_valid_o, ifc.busy_o, ifc.error_o); end
    ifc.req_valid_i = 4'b1111; ifc.req_opcode_i = '0; #1;
    n_vec++; if (ifc.req_ready_o !== 4'b0001) begin n_err++; $display("FAIL rstb_first: got %b want 0001", ifc.req_ready_o); end
    tick();
    ifc.req_valid_i = '0; ifc.isu_sc_ready_i = 1'b1; tick(); ifc.isu_sc_ready_i = 1'b0;
  endtask

  task automatic test_idle_ready();
    clear_inputs(); #2;
    n_vec++; if (ifc.busy_o !== 1'b0) begin n_err++; $display("FAIL idle_pre: busy %b want 0", ifc.busy_o); end
    ifc.isu_sc_ready_i = 1'b1; #1;
    n_vec++; if (ifc.done_valid_o !== 1'b0) begin n_err++; $display("FAIL idle_done: got %b want 0", ifc.done_valid_o); end
    tick();
    ifc.isu_sc_ready_i = 1'b0; #2;
    n_vec++; if (ifc.busy_o !== 1'b0 || ifc.isu_sc_valid_o !== 1'b0) begin n_err++; $display("FAIL idle_post: busy %b vld %b want 0 0", ifc.busy_o, ifc.isu_sc_valid_o); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = ($urandom_range(0, 149) == 0);
      ifc.req_valid_i = 4'($urandom); ifc.req_opcode_i = '0;
      for (int c = 0; c < 4; c++) ifc.req_opcode_i[c*3 +: 3] = 3'($urandom_range(0, 3));
      rand_payload();
      ifc.isu_sc_ready_i = ($urandom_range(0, 2) == 0);
      #2; model_eval();
      n_vec++; if (ifc.req_ready_o !== e_ready) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, ifc.req_ready_o, e_ready); end
      n_vec++; if (ifc.done_valid_o !== e_done || ifc.done_channel_id_o !== e_done_ch)
        begin n_err++; $display("FAIL rnd_done c%0d: got %b/%0d want %b/%0d", cyc, ifc.done_valid_o, ifc.done_channel_id_o, e_done, e_done_ch); end
      n_vec++; if (ifc.isu_sc_valid_o !== m_busy || ifc.busy_o !== m_busy || ifc.error_o !== m_err)
        begin n_err++; $display("FAIL rnd_state c%0d: vld %b busy %b err %b want %b %b %b", cyc, ifc.isu_sc_valid_o, ifc.busy_o, ifc.error_o, m_busy, m_busy, m_err); end
      n_vec++; if (ifc.isu_sc_channel_id_o !== 2'(m_chan) || ifc.isu_sc_opcode_o !== m_op || ifc.isu_sc_set_way_offset_o !== m_swo ||
                   ifc.isu_sc_wbuffer_id_o !== m_wbid || ifc.isu_sc_xbar_rob_num_o !== m_rob ||
                   ifc.isu_sc_cacheline_dirty_offset0_o !== m_d0 || ifc.isu_sc_cacheline_dirty_offset1_o !== m_d1)
        begin n_err++; $display("FAIL rnd_cmd c%0d: ch %0d op %0d swo %h wb %h rob %0d d %0d/%0d want %0d %0d %h %h %0d %0d/%0d", cyc,
          ifc.isu_sc_channel_id_o, ifc.isu_sc_opcode_o, ifc.isu_sc_set_way_offset_o, ifc.isu_sc_wbuffer_id_o, ifc.isu_sc_xbar_rob_num_o,
          ifc.isu_sc_cacheline_dirty_offset0_o, ifc.isu_sc_cacheline_dirty_offset1_o, m_chan, m_op, m_swo, m_wbid, m_rob, m_d0, m_d1); end
      tick();
    end
    rst = 1'b0; clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_wb_prio();
    test_timeout();
    test_reset_busy();
    test_idle_ready();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
